ctrl_pipe_regs: RTL and testbench

// - Carries the decoded control bundle from ID through the ID/EX, EX/MEM and MEM/WB pipeline registers.
// - Detects load-use hazards and inserts bubbles; squashes younger instructions on a taken branch.
// - Sits between the opcode decoder (ID) and the EX/MEM/WB datapath; drives the PC/IF-ID hold.

---
 rtl/ctrl_pipe_if.sv | 40 ++++
 rtl/ctrl_pipe_regs.sv | 89 ++++++++
 tb/tb_ctrl_pipe_regs.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_if.sv
// Control-bundle interface between the ID decoder, the pipeline control registers
// and the EX/MEM/WB datapath.
interface ctrl_pipe_if #(
    parameter int REG_ADDR_W = 3,
    parameter int ALUOP_W    = 2,
    parameter int CNT_W      = 8
) ();
    logic                  id_regDst, id_aluSrc, id_memtoReg, id_regWrite;
    logic                  id_memRead, id_memWrite, id_branch;
    logic [ALUOP_W-1:0]    id_aluOp;
    logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
    logic                  mem_branch_taken;

    logic                  ex_regDst, ex_aluSrc;
    logic [ALUOP_W-1:0]    ex_aluOp;
    logic                  ex_memRead, ex_memWrite, ex_branch, ex_memtoReg, ex_regWrite;
    logic                  mem_memRead, mem_memWrite, mem_branch, mem_memtoReg, mem_regWrite;
    logic                  wb_memtoReg, wb_regWrite;
    logic [REG_ADDR_W-1:0] ex_wrAddr, mem_wrAddr, wb_wrAddr;
    logic                  stall;
    logic [CNT_W-1:0]      stall_cnt, flush_cnt;

    modport master (
        output id_regDst, id_aluSrc, id_memtoReg, id_regWrite, id_memRead, id_memWrite,
               id_branch, id_aluOp, id_rs, id_rt, id_rd, mem_branch_taken,
        input  ex_regDst, ex_aluSrc, ex_aluOp, ex_memRead, ex_memWrite, ex_branch,
               ex_memtoReg, ex_regWrite, mem_memRead, mem_memWrite, mem_branch,
               mem_memtoReg, mem_regWrite, wb_memtoReg, wb_regWrite,
               ex_wrAddr, mem_wrAddr, wb_wrAddr, stall, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_regDst, id_aluSrc, id_memtoReg, id_regWrite, id_memRead, id_memWrite,
               id_branch, id_aluOp, id_rs, id_rt, id_rd, mem_branch_taken,
        output ex_regDst, ex_aluSrc, ex_aluOp, ex_memRead, ex_memWrite, ex_branch,
               ex_memtoReg, ex_regWrite, mem_memRead, mem_memWrite, mem_branch,
               mem_memtoReg, mem_regWrite, wb_memtoReg, wb_regWrite,
               ex_wrAddr, mem_wrAddr, wb_wrAddr, stall, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_pipe_regs.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use stall, branch flush
// and saturating stall/flush event counters.
module ctrl_pipe_regs #(
    parameter int REG_ADDR_W = 3,
    parameter int ALUOP_W    = 2,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    ctrl_pipe_if.slave  bus
);
    typedef struct packed {
        logic                  regDst, aluSrc;
        logic [ALUOP_W-1:0]    aluOp;
        logic                  memRead, memWrite, branch, memtoReg, regWrite;
        logic [REG_ADDR_W-1:0] wrAddr;
    } exCtl_t;

    typedef struct packed {
        logic                  memRead, memWrite, branch, memtoReg, regWrite;
        logic [REG_ADDR_W-1:0] wrAddr;
    } memCtl_t;

    typedef struct packed {
        logic                  memtoReg, regWrite;
        logic [REG_ADDR_W-1:0] wrAddr;
    } wbCtl_t;

    exCtl_t           idCtl, exQ;
    memCtl_t          memQ;
    wbCtl_t           wbQ;
    logic [CNT_W-1:0] stallCnt, flushCnt;
    logic             usesRt, hazard, stall, flush;

    always_comb begin
        idCtl = '{regDst:   bus.id_regDst,   aluSrc:   bus.id_aluSrc,
                  aluOp:    bus.id_aluOp,    memRead:  bus.id_memRead,
                  memWrite: bus.id_memWrite, branch:   bus.id_branch,
                  memtoReg: bus.id_memtoReg, regWrite: bus.id_regWrite,
                  wrAddr:   bus.id_regDst ? bus.id_rd : bus.id_rt};
    end

    // A taken branch squashes the instruction in ID anyway, so no point stalling it.
    assign flush  = bus.mem_branch_taken;
    assign usesRt = bus.id_regDst | bus.id_memWrite | bus.id_branch;
    assign hazard = exQ.memRead & exQ.regWrite &
                    ((exQ.wrAddr == bus.id_rs) | (usesRt & (exQ.wrAddr == bus.id_rt)));
    assign stall  = hazard & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exQ      <= '0;
            memQ     <= '0;
            wbQ      <= '0;
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            exQ  <= (flush | stall) ? '0 : idCtl;
            memQ <= flush ? '0 : '{memRead: exQ.memRead, memWrite: exQ.memWrite,
                                   branch: exQ.branch, memtoReg: exQ.memtoReg,
                                   regWrite: exQ.regWrite, wrAddr: exQ.wrAddr};
            wbQ  <= '{memtoReg: memQ.memtoReg, regWrite: memQ.regWrite, wrAddr: memQ.wrAddr};
            if (stall && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
            if (flush && flushCnt != '1) flushCnt <= flushCnt + 1'b1;
        end
    end

    assign bus.ex_regDst    = exQ.regDst;
    assign bus.ex_aluSrc    = exQ.aluSrc;
    assign bus.ex_aluOp     = exQ.aluOp;
    assign bus.ex_memRead   = exQ.memRead;
    assign bus.ex_memWrite  = exQ.memWrite;
    assign bus.ex_branch    = exQ.branch;
    assign bus.ex_memtoReg  = exQ.memtoReg;
    assign bus.ex_regWrite  = exQ.regWrite;
    assign bus.ex_wrAddr    = exQ.wrAddr;
    assign bus.mem_memRead  = memQ.memRead;
    assign bus.mem_memWrite = memQ.memWrite;
    assign bus.mem_branch   = memQ.branch;
    assign bus.mem_memtoReg = memQ.memtoReg;
    assign bus.mem_regWrite = memQ.regWrite;
    assign bus.mem_wrAddr   = memQ.wrAddr;
    assign bus.wb_memtoReg  = wbQ.memtoReg;
    assign bus.wb_regWrite  = wbQ.regWrite;
    assign bus.wb_wrAddr    = wbQ.wrAddr;
    assign bus.stall        = stall;
    assign bus.stall_cnt    = stallCnt;
    assign bus.flush_cnt    = flushCnt;
endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Self-checking bench for ctrl_pipe_regs: directed scenarios plus randomized
// traffic against an instruction-level pipeline model.
module tb_ctrl_pipe_regs;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ctrl_pipe_if #(.REG_ADDR_W(3), .ALUOP_W(2), .CNT_W(8)) bus ();
    ctrl_pipe_regs #(.REG_ADDR_W(3), .ALUOP_W(2), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        bit regDst, aluSrc, memRead, memWrite, branch, memtoReg, regWrite;
        bit [1:0] aluOp;
        bit [2:0] wr;
    } ctl_t;

    ctl_t mEx, mMem, mWb;
    int   mStallCnt, mFlushCnt;

    function automatic ctl_t fromId();
        ctl_t c = '0;
        c.regDst = bus.id_regDst;     c.aluSrc = bus.id_aluSrc;   c.memRead = bus.id_memRead;
        c.memWrite = bus.id_memWrite; c.branch = bus.id_branch;   c.memtoReg = bus.id_memtoReg;
        c.regWrite = bus.id_regWrite; c.aluOp = bus.id_aluOp;
        c.wr = bus.id_regDst ? bus.id_rd : bus.id_rt;
        return c;
    endfunction

    function automatic ctl_t memPart(ctl_t e);
        ctl_t c = '0;
        c.memRead = e.memRead; c.memWrite = e.memWrite; c.branch = e.branch;
        c.memtoReg = e.memtoReg; c.regWrite = e.regWrite; c.wr = e.wr;
        return c;
    endfunction

    function automatic ctl_t wbPart(ctl_t m);
        ctl_t c = '0;
        c.memtoReg = m.memtoReg; c.regWrite = m.regWrite; c.wr = m.wr;
        return c;
    endfunction

    function automatic ctl_t gotEx();
        ctl_t c = '0;
        c.regDst = bus.ex_regDst;     c.aluSrc = bus.ex_aluSrc;   c.memRead = bus.ex_memRead;
        c.memWrite = bus.ex_memWrite; c.branch = bus.ex_branch;   c.memtoReg = bus.ex_memtoReg;
        c.regWrite = bus.ex_regWrite; c.aluOp = bus.ex_aluOp;     c.wr = bus.ex_wrAddr;
        return c;
    endfunction

    function automatic ctl_t gotMem();
        ctl_t c = '0;
        c.memRead = bus.mem_memRead; c.memWrite = bus.mem_memWrite; c.branch = bus.mem_branch;
        c.memtoReg = bus.mem_memtoReg; c.regWrite = bus.mem_regWrite; c.wr = bus.mem_wrAddr;
        return c;
    endfunction

    function automatic ctl_t gotWb();
        ctl_t c = '0;
        c.memtoReg = bus.wb_memtoReg; c.regWrite = bus.wb_regWrite; c.wr = bus.wb_wrAddr;
        return c;
    endfunction

    // A load in EX whose target the ID instruction reads forces one bubble, unless a branch squashes ID.
    function automatic bit modelStall();
        bit readsRt = bus.id_regDst | bus.id_memWrite | bus.id_branch;
        bit dep = (mEx.wr == bus.id_rs) || (readsRt && mEx.wr == bus.id_rt);
        return mEx.memRead && mEx.regWrite && dep && !bus.mem_branch_taken;
    endfunction

    task automatic modelReset();
        mEx = '0; mMem = '0; mWb = '0; mStallCnt = 0; mFlushCnt = 0;
    endtask

    task automatic step();
        bit   st = modelStall();
        bit   fl = bus.mem_branch_taken;
        ctl_t nEx  = (st || fl) ? ctl_t'(0) : fromId();
        ctl_t nMem = fl ? ctl_t'(0) : memPart(mEx);
        ctl_t nWb  = wbPart(mMem);
        @(posedge clk);
        #1;
        mEx = nEx; mMem = nMem; mWb = nWb;
        if (st) mStallCnt = (mStallCnt < 255) ? mStallCnt + 1 : 255;
        if (fl) mFlushCnt = (mFlushCnt < 255) ? mFlushCnt + 1 : 255;
    endtask

    task automatic idle();
        bus.id_regDst = 0; bus.id_aluSrc = 0; bus.id_memtoReg = 0; bus.id_regWrite = 0;
        bus.id_memRead = 0; bus.id_memWrite = 0; bus.id_branch = 0; bus.id_aluOp = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.mem_branch_taken = 0;
    endtask

    task automatic putRtype(input bit [2:0] rs, input bit [2:0] rt, input bit [2:0] rd);
        idle();
        bus.id_regDst = 1; bus.id_regWrite = 1; bus.id_aluOp = 2;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    endtask

    task automatic putLw(input bit [2:0] rs, input bit [2:0] rt);
        idle();
        bus.id_memRead = 1; bus.id_regWrite = 1; bus.id_memtoReg = 1; bus.id_aluSrc = 1;
        bus.id_rs = rs; bus.id_rt = rt;
    endtask

    task automatic pulseReset();
        rst = 1; #2; rst = 0;
        modelReset();
    endtask

    task automatic test_reset();
        idle();
        #1;
        checks++; if (gotEx() !== '0 || gotMem() !== '0 || gotWb() !== '0) begin
            errors++; $display("FAIL reset_stages got %h/%h/%h exp 0", gotEx(), gotMem(), gotWb()); end
        checks++; if (bus.stall !== 1'b0 || bus.stall_cnt !== 8'd0 || bus.flush_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_misc stall=%b sc=%0d fc=%0d exp 0", bus.stall, bus.stall_cnt, bus.flush_cnt); end
        @(posedge clk); #1;
        rst = 0;
        modelReset();
    endtask

    task automatic test_rtype();
        pulseReset();
        putRtype(3'd1, 3'd2, 3'd5);
        step(); idle();
        checks++; if (bus.ex_regDst !== 1 || bus.ex_regWrite !== 1 || bus.ex_aluOp !== 2'd2 || bus.ex_wrAddr !== 3'd5) begin
            errors++; $display("FAIL rtype_ex got %h exp regDst,regWrite,aluOp=2,wr=5", gotEx()); end
        step();
        checks++; if (bus.mem_regWrite !== 1 || bus.mem_wrAddr !== 3'd5 || bus.ex_regWrite !== 0) begin
            errors++; $display("FAIL rtype_mem got mem %h ex %h exp regWrite wr=5", gotMem(), gotEx()); end
        step();
        checks++; if (bus.wb_regWrite !== 1 || bus.wb_wrAddr !== 3'd5 || bus.wb_memtoReg !== 0) begin
            errors++; $display("FAIL rtype_wb got %h exp regWrite wr=5", gotWb()); end
    endtask

    task automatic test_load_use();
        pulseReset();
        putLw(3'd0, 3'd3);
        step();
        putRtype(3'd3, 3'd1, 3'd6);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", bus.stall); end
        step();
        checks++; if (gotEx() !== '0 || bus.stall_cnt !== 8'd1) begin
            errors++; $display("FAIL lu_bubble got ex %h sc=%0d exp 0 / 1", gotEx(), bus.stall_cnt); end
        checks++; if (bus.stall !== 1'b0 || bus.mem_memRead !== 1'b1 || bus.mem_wrAddr !== 3'd3) begin
            errors++; $display("FAIL lu_release got stall=%b mem %h exp 0 / lw", bus.stall, gotMem()); end
        step(); idle();
        checks++; if (bus.ex_regDst !== 1 || bus.ex_wrAddr !== 3'd6 || bus.stall_cnt !== 8'd1) begin
            errors++; $display("FAIL lu_late_add got ex %h sc=%0d exp add wr=6 / 1", gotEx(), bus.stall_cnt); end
    endtask

    task automatic test_sw_no_hazard();
        pulseReset();
        putLw(3'd0, 3'd3);
        step();
        idle();
        bus.id_memWrite = 1; bus.id_aluSrc = 1; bus.id_rs = 3'd1; bus.id_rt = 3'd4;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sw_stall got %b exp 0", bus.stall); end
        step(); idle();
        checks++; if (bus.ex_memWrite !== 1'b1 || bus.ex_wrAddr !== 3'd4 || bus.stall_cnt !== 8'd0) begin
            errors++; $display("FAIL sw_ex got %h sc=%0d exp sw wr=4 / 0", gotEx(), bus.stall_cnt); end
    endtask

    task automatic test_flush_priority();
        pulseReset();
        idle(); bus.id_branch = 1; bus.id_rs = 3'd1; bus.id_rt = 3'd2;
        step();
        putLw(3'd0, 3'd3);
        step();
        putRtype(3'd3, 3'd1, 3'd6);
        bus.mem_branch_taken = 1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %b exp 0", bus.stall); end
        step(); idle();
        checks++; if (gotEx() !== '0 || gotMem() !== '0) begin
            errors++; $display("FAIL fl_squash got ex %h mem %h exp 0", gotEx(), gotMem()); end
        checks++; if (bus.wb_regWrite !== 0 || bus.wb_memtoReg !== 0 || bus.wb_wrAddr !== 3'd2) begin
            errors++; $display("FAIL fl_wb got %h exp wr=2 regWrite 0", gotWb()); end
        checks++; if (bus.flush_cnt !== 8'd1 || bus.stall_cnt !== 8'd0) begin
            errors++; $display("FAIL fl_cnt got fc=%0d sc=%0d exp 1 / 0", bus.flush_cnt, bus.stall_cnt); end
    endtask

    task automatic test_saturation();
        pulseReset();
        putLw(3'd3, 3'd3);   // self-dependent load stalls on every other cycle
        for (int i = 0; i < 600; i++) step();
        checks++; if (bus.stall_cnt !== 8'd255) begin
            errors++; $display("FAIL sat_stall got %0d exp 255", bus.stall_cnt); end
        step(); step();
        checks++; if (bus.stall_cnt !== 8'd255) begin
            errors++; $display("FAIL sat_stall_hold got %0d exp 255", bus.stall_cnt); end
        idle(); bus.mem_branch_taken = 1;
        for (int i = 0; i < 300; i++) step();
        checks++; if (bus.flush_cnt !== 8'd255 || bus.stall !== 1'b0) begin
            errors++; $display("FAIL sat_flush got fc=%0d stall=%b exp 255 / 0", bus.flush_cnt, bus.stall); end
        idle();
    endtask

    task automatic test_mid_reset();
        pulseReset();
        putRtype(3'd1, 3'd1, 3'd5); step();
        putRtype(3'd1, 3'd1, 3'd6); step();
        putLw(3'd0, 3'd2); step();
        putRtype(3'd2, 3'd0, 3'd7);
        #1;
        checks++; if (bus.stall !== 1'b1 || bus.wb_regWrite !== 1'b1) begin
            errors++; $display("FAIL mr_prefill got stall=%b wb %h exp 1 / rtype", bus.stall, gotWb()); end
        rst = 1;
        #1;
        checks++; if (gotEx() !== '0 || gotMem() !== '0 || gotWb() !== '0 || bus.stall !== 1'b0) begin
            errors++; $display("FAIL mr_clear got %h/%h/%h stall=%b exp 0", gotEx(), gotMem(), gotWb(), bus.stall); end
        rst = 0;
        modelReset();
        putRtype(3'd1, 3'd1, 3'd7);
        step(); idle(); step(); step();
        checks++; if (bus.wb_regWrite !== 1'b1 || bus.wb_wrAddr !== 3'd7) begin
            errors++; $display("FAIL mr_resume got %h exp regWrite wr=7", gotWb()); end
    endtask

    task automatic test_random();
        pulseReset();
        for (int i = 0; i < 500; i++) begin
            bus.id_regDst = 1'($urandom); bus.id_aluSrc = 1'($urandom);
            bus.id_memtoReg = 1'($urandom); bus.id_regWrite = ($urandom_range(3) != 0);
            bus.id_memRead = ($urandom_range(2) == 0); bus.id_memWrite = 1'($urandom);
            bus.id_branch = ($urandom_range(3) == 0); bus.id_aluOp = 2'($urandom);
            bus.id_rs = 3'($urandom_range(3)); bus.id_rt = 3'($urandom_range(3));
            bus.id_rd = 3'($urandom);
            bus.mem_branch_taken = ($urandom_range(7) == 0);
            #1;
            checks++; if (bus.stall !== modelStall()) begin
                errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", i, bus.stall, modelStall()); end
            step();
            checks++; if (gotEx() !== mEx) begin
                errors++; $display("FAIL rnd_ex cyc %0d got %h exp %h", i, gotEx(), mEx); end
            checks++; if (gotMem() !== mMem) begin
                errors++; $display("FAIL rnd_mem cyc %0d got %h exp %h", i, gotMem(), mMem); end
            checks++; if (gotWb() !== mWb) begin
                errors++; $display("FAIL rnd_wb cyc %0d got %h exp %h", i, gotWb(), mWb); end
            checks++; if (int'(bus.stall_cnt) != mStallCnt || int'(bus.flush_cnt) != mFlushCnt) begin
                errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d/%0d",
                                   i, bus.stall_cnt, bus.flush_cnt, mStallCnt, mFlushCnt); end
        end
        idle();
    endtask

    initial begin
        modelReset();
        test_reset();
        test_rtype();
        test_load_use();
        test_sw_no_hazard();
        test_flush_priority();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
